// File: rtl/spi_regif_pkg.sv
// spi_regif_pkg
//   Shared definitions for the SPI-to-register-bus responder:
//   - frame decoder FSM state encoding
//   - command byte layout and bus widths
package spi_regif_pkg;

  // Position of the read/not-write flag inside the command byte.
  localparam int CMD_RW_BIT = 7;
  // Register address width (command byte bits 6:0).
  localparam int ADDR_W     = 7;
  // Register data width; also the SPI byte length.
  localparam int DATA_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a fresh chip-select falling edge
    CMD  = 2'd1,  // shifting in the command byte
    DATA = 2'd2   // shifting data bytes in (write) or out (read)
  } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync
//   Multi-flop synchronizer for one asynchronous input, followed by a history
//   flop so that edges of the synchronized level can be detected.
//   All flops reset to 0.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   din_i   in   asynchronous input
//   level_o out  synchronized level (last synchronizer stage)
//   rise_o  out  one-cycle pulse on a 0->1 change of level_o
//   fall_o  out  one-cycle pulse on a 1->0 change of level_o
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/spi_slave_regif.sv
// spi_slave_regif
//   SPI mode-0 responder that turns SPI frames into register-bus strobes.
//   Frame: command byte {R/nW, addr[6:0]} followed by any number of data bytes,
//   MSB first. Writes strobe reg_we once per completed data byte; reads strobe
//   reg_re for the command byte and for every completed data byte, and the
//   returned reg_rdata is shifted out on MISO. All SPI inputs are oversampled
//   in the clk domain (SCK must be no faster than clk/8).
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   spi_sck, spi_cs_n,  SPI clock, chip select (active low), master data
//   spi_mosi
//   spi_miso            data to master, updated on SCK falling edges
//   spi_miso_oe         MISO pad enable, high while a frame is active
//   reg_addr            register address (auto-increments when AUTO_INC != 0)
//   reg_wdata, reg_we   write data and one-cycle write strobe
//   reg_re, reg_rdata   one-cycle read strobe; data expected the cycle after
//   busy                high while a frame is active
module spi_slave_regif
  import spi_regif_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (spi_sck),
    .level_o(sck_level),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  // The cs_n synchronizer resets to 0 (as if selected) on purpose: if cs_n is
  // already low when reset is released no falling edge is seen, so the block
  // stays in IDLE until the master deselects and selects again.
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (spi_cs_n),
    .level_o(cs_level),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // MOSI goes through the same latency as SCK so it is aligned with sck_rise.
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (spi_mosi),
    .level_o(mosi_level),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sck_level, cs_rise, mosi_rise, mosi_fall};

  spi_state_e        state_q;
  logic [2:0]        bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [DATA_W-1:0] tx_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_pend_q;
  logic              we_q;
  logic              re_pend_q;
  logic              re_q;
  logic              load_q;
  logic              miso_q;
  logic              oe_q;
  logic              busy_q;
  logic              byte_done;

  assign shift_d   = {shift_q[DATA_W-2:0], mosi_level};
  assign byte_done = (bit_cnt_q == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_pend_q <= 1'b0;
      we_q      <= 1'b0;
      re_pend_q <= 1'b0;
      re_q      <= 1'b0;
      load_q    <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // Strobe pipeline: wdata is latched one cycle before reg_we, and in
      // read data bytes the address moves one cycle before reg_re. Pending
      // strobes of a completed byte still drain if cs_n rises meanwhile.
      we_q      <= we_pend_q;
      we_pend_q <= 1'b0;
      re_q      <= re_pend_q;
      re_pend_q <= 1'b0;
      // reg_rdata is valid the cycle after reg_re; capture it then.
      load_q    <= re_q;

      // Post-write increment, with reg_addr held stable during the strobe.
      if (we_q && (AUTO_INC != 0)) begin
        addr_q <= addr_q + ADDR_ONE;
      end

      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= CMD;
            bit_cnt_q <= '0;
            oe_q      <= 1'b1;
            miso_q    <= 1'b0;
            busy_q    <= 1'b1;
          end
        end

        CMD: begin
          if (sck_rise) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (byte_done) begin
              rw_q    <= shift_d[CMD_RW_BIT];
              addr_q  <= shift_d[ADDR_W-1:0];
              state_q <= DATA;
              // Read frames fetch the first byte right away.
              re_q    <= shift_d[CMD_RW_BIT];
            end
          end
        end

        DATA: begin
          if (sck_rise) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (byte_done) begin
              if (rw_q) begin
                if (AUTO_INC != 0) begin
                  addr_q <= addr_q + ADDR_ONE;
                end
                re_pend_q <= 1'b1;
              end else begin
                wdata_q   <= shift_d;
                we_pend_q <= 1'b1;
              end
            end
          end
          if (rw_q && sck_fall) begin
            miso_q <= tx_q[DATA_W-1];
            tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
          end
        end

        default: state_q <= IDLE;
      endcase

      // The clk/8 SCK bound keeps this reload clear of the next SCK fall.
      if (load_q) begin
        tx_q <= reg_rdata;
      end

      // Deselect aborts from any state; a partial byte is simply dropped.
      if (cs_level) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
        miso_q  <= 1'b0;
        busy_q  <= 1'b0;
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_we      = we_q;
  assign reg_re      = re_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_regif.sv
`timescale 1ns/1ps
module tb_spi_slave_regif;

  localparam int SYNC = 2;

  typedef logic [7:0] byte_q_t [$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sck;
  logic       mosi;
  logic       cs_n  [2];
  logic       miso  [2];
  logic       oe    [2];
  logic       we    [2];
  logic       re    [2];
  logic       busy  [2];
  logic [6:0] addr  [2];
  logic [7:0] wdata [2];
  logic [7:0] rdata [2];

  // Instance 0 auto-increments, instance 1 holds the address.
  spi_slave_regif #(.SYNC_STAGES(SYNC), .AUTO_INC(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .spi_sck(sck), .spi_cs_n(cs_n[0]), .spi_mosi(mosi),
    .spi_miso(miso[0]), .spi_miso_oe(oe[0]), .reg_addr(addr[0]), .reg_wdata(wdata[0]),
    .reg_we(we[0]), .reg_re(re[0]), .reg_rdata(rdata[0]), .busy(busy[0])
  );

  spi_slave_regif #(.SYNC_STAGES(SYNC), .AUTO_INC(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .spi_sck(sck), .spi_cs_n(cs_n[1]), .spi_mosi(mosi),
    .spi_miso(miso[1]), .spi_miso_oe(oe[1]), .reg_addr(addr[1]), .reg_wdata(wdata[1]),
    .reg_we(we[1]), .reg_re(re[1]), .reg_rdata(rdata[1]), .busy(busy[1])
  );

  int checks   = 0;
  int failures = 0;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Register file seen by the DUTs, and the model's expectation of it.
  logic [7:0] dmem    [2][128];
  logic [7:0] ref_mem [2][128];

  int          act = 0;
  logic [14:0] wq[$];
  logic [6:0]  rq[$];
  logic [7:0]  rx_q[$];
  int          we_cycle   = 0;
  int          rise_cycle = 0;
  int          stray      = 0;
  bit          both_seen  = 0;
  int          oe_bad     = 0;
  bit          lat_check  = 0;
  bit          pend  [2];
  logic [6:0]  paddr [2];

  // Bus monitor and register file responder.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (we[i] === 1'b1 && re[i] === 1'b1) both_seen = 1'b1;
      if (we[i] === 1'b1) begin
        dmem[i][addr[i]] = wdata[i];
        if (i == act) begin
          wq.push_back({addr[i], wdata[i]});
          we_cycle = cycle_cnt;
        end else begin
          stray++;
        end
      end
      if (re[i] === 1'b1) begin
        pend[i]  = 1'b1;
        paddr[i] = addr[i];
        if (i == act) rq.push_back(addr[i]);
        else          stray++;
      end
    end
  end

  // Read data is valid only in the cycle after reg_re; garbage otherwise.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) begin
        rdata[i] = dmem[i][paddr[i]];
        pend[i]  = 1'b0;
      end else begin
        rdata[i] = 8'($urandom);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI bit at SCK = clk/8; the master samples MISO just before rising.
  task automatic xfer_bit(input int idx, input logic b, output logic r);
    mosi = b;
    tick(4);
    r = miso[idx];
    if (oe[idx] !== 1'b1) oe_bad++;
    sck = 1'b1;
    rise_cycle = cycle_cnt;
    tick(4);
    sck = 1'b0;
  endtask

  task automatic run_frame(input int idx, input byte_q_t bytes, input int extra);
    logic [7:0] cur;
    logic [7:0] rb;
    logic       r;
    rx_q.delete();
    cs_n[idx] = 1'b0;
    if (lat_check) begin
      @(posedge clk); @(posedge clk); @(negedge clk);
      checks++;
      if (busy[idx] !== 1'b0) begin
        failures++;
        $display("FAIL busy_latency_early got=%b exp=0", busy[idx]);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (busy[idx] !== 1'b1) begin
        failures++;
        $display("FAIL busy_latency got=%b exp=1", busy[idx]);
      end
      @(posedge clk);
      #1;
    end
    tick(8);
    for (int k = 0; k < bytes.size(); k++) begin
      cur = bytes[k];
      rb  = '0;
      for (int b = 7; b >= 0; b--) begin
        xfer_bit(idx, cur[b], r);
        rb[b] = r;
      end
      if (k > 0) rx_q.push_back(rb);
    end
    for (int e = 0; e < extra; e++) xfer_bit(idx, 1'($urandom_range(0, 1)), r);
    tick(6);
    cs_n[idx] = 1'b1;
    tick(12);
  endtask

  // Runs one frame and checks it against the frame-level model:
  // write frames store each full data byte at addr, addr+1, ...;
  // read frames fetch at the command and after every full data byte, and the
  // master receives one fetched byte per data byte.
  task automatic do_frame(input int idx, input byte_q_t bytes, input int extra, input string name);
    logic [14:0] ew[$];
    logic [6:0]  er[$];
    logic [7:0]  erx[$];
    logic [7:0]  cmd;
    logic [6:0]  a;
    int          inc;
    inc = (idx == 0) ? 1 : 0;
    cmd = bytes[0];
    a   = cmd[6:0];
    if (cmd[7]) er.push_back(a);
    for (int k = 1; k < bytes.size(); k++) begin
      if (cmd[7]) begin
        erx.push_back(ref_mem[idx][a]);
        a = a + 7'(inc);
        er.push_back(a);
      end else begin
        ew.push_back({a, bytes[k]});
        a = a + 7'(inc);
      end
    end

    act = idx;
    wq.delete();
    rq.delete();
    oe_bad = 0;
    run_frame(idx, bytes, extra);

    checks++;
    if (wq.size() != ew.size()) begin
      failures++;
      $display("FAIL %s write_count got=%0d exp=%0d", name, wq.size(), ew.size());
    end
    for (int k = 0; k < ew.size() && k < wq.size(); k++) begin
      checks++;
      if (wq[k] !== ew[k]) begin
        failures++;
        $display("FAIL %s write[%0d] got addr=%h data=%h exp addr=%h data=%h",
                 name, k, wq[k][14:8], wq[k][7:0], ew[k][14:8], ew[k][7:0]);
      end
    end
    checks++;
    if (rq.size() != er.size()) begin
      failures++;
      $display("FAIL %s read_count got=%0d exp=%0d", name, rq.size(), er.size());
    end
    for (int k = 0; k < er.size() && k < rq.size(); k++) begin
      checks++;
      if (rq[k] !== er[k]) begin
        failures++;
        $display("FAIL %s read_addr[%0d] got=%h exp=%h", name, k, rq[k], er[k]);
      end
    end
    for (int k = 0; k < erx.size() && k < rx_q.size(); k++) begin
      checks++;
      if (rx_q[k] !== erx[k]) begin
        failures++;
        $display("FAIL %s miso_byte[%0d] got=%h exp=%h", name, k, rx_q[k], erx[k]);
      end
    end
    checks++;
    if (oe_bad != 0) begin
      failures++;
      $display("FAIL %s oe_in_frame got=%0d_low_samples exp=0", name, oe_bad);
    end
    checks++;
    if (oe[idx] !== 1'b0 || busy[idx] !== 1'b0 || miso[idx] !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after got oe=%b busy=%b miso=%b exp=0/0/0", name, oe[idx], busy[idx], miso[idx]);
    end
    foreach (ew[k]) ref_mem[idx][ew[k][14:8]] = ew[k][7:0];
    $display("frame %s dut=%0d bytes=%0d extra_bits=%0d writes=%0d reads=%0d", name, idx, bytes.size(), extra, wq.size(), rq.size());
  endtask

  task automatic check_zero(input int i, input string name);
    checks++;
    if (miso[i] !== 1'b0 || oe[i] !== 1'b0 || addr[i] !== 7'h0 || wdata[i] !== 8'h0 ||
        we[i] !== 1'b0 || re[i] !== 1'b0 || busy[i] !== 1'b0) begin
      failures++;
      $display("FAIL %s dut=%0d got miso=%b oe=%b addr=%h wdata=%h we=%b re=%b busy=%b exp all 0",
               name, i, miso[i], oe[i], addr[i], wdata[i], we[i], re[i], busy[i]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst_n = 1'b1;
    tick(6);
    check_zero(0, "post_reset_idle");
    check_zero(1, "post_reset_idle");
    $display("test_reset done");
  endtask

  task automatic test_single_write();
    byte_q_t q;
    q.push_back(8'h05); q.push_back(8'hA5);
    lat_check = 1'b1;
    do_frame(0, q, 0, "single_write");
    lat_check = 1'b0;
    checks++;
    if (we_cycle - rise_cycle != SYNC + 2) begin
      failures++;
      $display("FAIL write_latency got=%0d exp=%0d", we_cycle - rise_cycle, SYNC + 2);
    end
  endtask

  task automatic test_single_read();
    byte_q_t q;
    dmem[0][3] = 8'h3C; ref_mem[0][3] = 8'h3C;
    q.push_back(8'h83); q.push_back(8'($urandom));
    do_frame(0, q, 0, "single_read");
  endtask

  task automatic test_burst_write_wrap();
    byte_q_t q;
    q.push_back(8'h7E); q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    do_frame(0, q, 0, "burst_write_wrap");
  endtask

  task automatic test_burst_read_noinc();
    byte_q_t q;
    dmem[1][16] = 8'h5A; ref_mem[1][16] = 8'h5A;
    q.push_back(8'h90);
    for (int k = 0; k < 3; k++) q.push_back(8'($urandom));
    do_frame(1, q, 0, "burst_read_noinc");
  endtask

  task automatic test_aborted();
    byte_q_t q;
    byte_q_t q2;
    q.push_back(8'h02);
    do_frame(0, q, 5, "aborted");
    q2.push_back(8'h02); q2.push_back(8'hFF);
    do_frame(0, q2, 0, "after_abort");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] cmd;
    logic       r;
    cmd = 8'h05;
    act = 0;
    cs_n[0] = 1'b0;
    tick(8);
    for (int b = 7; b >= 0; b--) xfer_bit(0, cmd[b], r);
    for (int b = 0; b < 3; b++) xfer_bit(0, 1'b1, r);
    mosi = 1'b1;
    tick(2);
    rst_n = 1'b0;
    #1;
    check_zero(0, "reset_midframe");
    tick(2);
    rst_n = 1'b1;
    wq.delete();
    rq.delete();
    tick(2);
    sck = 1'b1; tick(4); sck = 1'b0;
    for (int b = 0; b < 8; b++) xfer_bit(0, 1'($urandom_range(0, 1)), r);
    tick(10);
    checks++;
    if (wq.size() != 0 || rq.size() != 0) begin
      failures++;
      $display("FAIL reset_release_strobes got we=%0d re=%0d exp=0/0", wq.size(), rq.size());
    end
    checks++;
    if (busy[0] !== 1'b0 || oe[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle got busy=%b oe=%b exp=0/0", busy[0], oe[0]);
    end
    cs_n[0] = 1'b1;
    tick(12);
    $display("test_reset_midframe done");
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      byte_q_t q;
      int      nd;
      int      extra;
      q.push_back(8'($urandom));
      nd    = $urandom_range(0, 3);
      extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      for (int k = 0; k < nd; k++) q.push_back(8'($urandom));
      do_frame(0, q, extra, "random");
    end
  endtask

  task automatic test_strobe_exclusive();
    checks++;
    if (both_seen !== 1'b0) begin
      failures++;
      $display("FAIL we_re_overlap got=%b exp=0", both_seen);
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL deselected_strobes got=%0d exp=0", stray);
    end
  endtask

  initial begin
    sck = 1'b0; mosi = 1'b0;
    cs_n[0] = 1'b1; cs_n[1] = 1'b1;
    rdata[0] = '0; rdata[1] = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    paddr[0] = '0; paddr[1] = '0;
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 128; a++) begin
        dmem[i][a]    = 8'($urandom);
        ref_mem[i][a] = dmem[i][a];
      end
    end
    test_reset();
    test_single_write();
    test_single_read();
    test_burst_write_wrap();
    test_burst_read_noinc();
    test_aborted();
    test_reset_midframe();
    test_random();
    test_strobe_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
